pcileech_bar_cpl_tlp_gen: RTL

//  Downstream of the BAR implementation: converts each single-DW BAR read reply (ctx+data) into a PCIe CplD TLP.

---
 rtl/pcileech_bar_cpl_tlp_gen_if.sv | 39 +++
 rtl/pcileech_bar_cpl_tlp_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_bar_cpl_tlp_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_bar_cpl_tlp_gen_if
// Description : 64-bit valid/ready TLP beat stream carrying completion TLPs
//               toward the TLP TX mux.
//               master : TLP source (drives data/keep/last/valid)
//               slave  : TLP sink   (drives ready)
//               Signals:
//                 tlp_tdata  [63:0]  beat, DW0 in [31:0], DW1 in [63:32]
//                 tlp_tkeep  [1:0]   per-DW valid
//                 tlp_tlast          last beat of the TLP
//                 tlp_tvalid         beat valid
//                 tlp_tready         sink accepts the beat
// Revision    : 1.0 - initial release
// ============================================================================
interface pcileech_bar_cpl_tlp_gen_if;
    logic [63:0] tlp_tdata;
    logic [1:0]  tlp_tkeep;
    logic        tlp_tlast;
    logic        tlp_tvalid;
    logic        tlp_tready;

    modport master (
        output tlp_tdata,
        output tlp_tkeep,
        output tlp_tlast,
        output tlp_tvalid,
        input  tlp_tready
    );

    modport slave (
        input  tlp_tdata,
        input  tlp_tkeep,
        input  tlp_tlast,
        input  tlp_tvalid,
        output tlp_tready
    );
endinterface
`default_nettype wire

// File: rtl/pcileech_bar_cpl_tlp_gen.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_bar_cpl_tlp_gen
// Description : Converts single-DW BAR read replies (ctx + data) into PCIe
//               CplD TLPs. Replies are buffered in a FIFO since the reply port
//               has no backpressure; each TLP leaves as two 64-bit beats.
// Ports       :
//   clk              core clock, posedge
//   rst              synchronous active-high reset
//   i_completer_id   bus/dev/fn of this function, sampled at header build
//   i_rd_rsp_ctx     reply context (lower addr, tag, requester ID, byte count)
//   i_rd_rsp_data    reply data DW
//   i_rd_rsp_valid   one reply per asserted cycle, no ready
//   tlp              TLP beat stream (master side)
//   o_fifo_level     FIFO occupancy, 0..DEPTH
//   o_overflow       1-cycle pulse when a reply was dropped
//   o_ovf_count      (BAR_CPL_STATS_EN) saturating dropped-reply count
//   o_level_max      (BAR_CPL_STATS_EN) high-water mark of o_fifo_level
// Config      : define BAR_CPL_STATS_EN to add the statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pcileech_bar_cpl_tlp_gen #(
    parameter int FIFO_AW = 4
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire  [15:0]            i_completer_id,
    input  wire  [87:0]            i_rd_rsp_ctx,
    input  wire  [31:0]            i_rd_rsp_data,
    input  wire                    i_rd_rsp_valid,
    pcileech_bar_cpl_tlp_gen_if.master tlp,
    output logic [FIFO_AW:0]       o_fifo_level,
    output logic                   o_overflow
`ifdef BAR_CPL_STATS_EN
    ,
    output logic [15:0]            o_ovf_count,
    output logic [FIFO_AW:0]       o_level_max
`endif
);

    localparam int                 c_DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   c_DEPTH_LV = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic [FIFO_AW:0]   c_ONE_LV   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] c_ONE_PTR  = FIFO_AW'(1);
    // fmt=010 (3DW w/ data), type=01010 (Cpl), length=1
    localparam logic [31:0]        c_CPLD_DW0 = 32'h4A00_0001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [119:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_level;
    logic [FIFO_AW:0]     w_level_nxt;
    logic                 r_overflow;
    logic [63:0]          r_beat0;
    logic [63:0]          r_beat1;

    logic                 w_load;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [FIFO_AW-1:0]   w_rd_idx;
    logic [119:0]         w_head;
    logic [63:0]          w_beat0;
    logic [63:0]          w_beat1;
    logic                 w_unused_head;

    // ------------------------------------------------------------------
    // FIFO push/pop. A pop in the same cycle frees a slot, so a full FIFO
    // can still accept a reply when beat1 handshakes.
    // ------------------------------------------------------------------
    assign w_push = i_rd_rsp_valid && ((r_level != c_DEPTH_LV) || w_pop);
    assign w_drop = i_rd_rsp_valid && !w_push;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_ONE_LV;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - c_ONE_LV;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_rd_rsp_data, i_rd_rsp_ctx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ONE_PTR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE_PTR;
            end
            r_level    <= w_level_nxt;
            r_overflow <= w_drop;
        end
    end

    // When popping and reloading in one cycle the next entry sits one
    // slot beyond the current read pointer.
    assign w_rd_idx = w_pop ? (r_rd_ptr + c_ONE_PTR) : r_rd_ptr;
    assign w_head   = r_mem[w_rd_idx];

    // Entry layout: [119:88] data, [87:0] ctx.
    // ctx: [6:0] lower addr, [15:8] tag, [31:16] req ID, [43:32] byte count.
    assign w_beat0 = {i_completer_id, 3'b000, 1'b0, w_head[43:32], c_CPLD_DW0};
    assign w_beat1 = {w_head[119:88], w_head[31:16], w_head[15:8], 1'b0, w_head[6:0]};

    // ctx bits [7] and [87:44] carry nothing for the completion header.
    assign w_unused_head = ^{w_head[87:44], w_head[7]};

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (tlp.tlp_tready) begin
                    w_state_nxt = S_BEAT1;
                end
            end
            S_BEAT1: begin
                if (tlp.tlp_tready) begin
                    w_pop = 1'b1;
                    // The head entry is still counted in r_level until popped.
                    if (r_level > c_ONE_LV) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_BEAT0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Both beats are captured together so data stays stable under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat0 <= '0;
            r_beat1 <= '0;
        end else if (w_load) begin
            r_beat0 <= w_beat0;
            r_beat1 <= w_beat1;
        end
    end

    always_comb begin
        tlp.tlp_tdata  = '0;
        tlp.tlp_tkeep  = 2'b00;
        tlp.tlp_tlast  = 1'b0;
        tlp.tlp_tvalid = 1'b0;
        case (r_state)
            S_BEAT0: begin
                tlp.tlp_tdata  = r_beat0;
                tlp.tlp_tkeep  = 2'b11;
                tlp.tlp_tvalid = 1'b1;
            end
            S_BEAT1: begin
                tlp.tlp_tdata  = r_beat1;
                tlp.tlp_tkeep  = 2'b11;
                tlp.tlp_tlast  = 1'b1;
                tlp.tlp_tvalid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_fifo_level = r_level;
    assign o_overflow   = r_overflow;

`ifdef BAR_CPL_STATS_EN
    logic [15:0]      r_ovf_count;
    logic [FIFO_AW:0] r_level_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_count <= '0;
            r_level_max <= '0;
        end else begin
            if (w_drop && (r_ovf_count != 16'hFFFF)) begin
                r_ovf_count <= r_ovf_count + 16'd1;
            end
            if (w_level_nxt > r_level_max) begin
                r_level_max <= w_level_nxt;
            end
        end
    end

    assign o_ovf_count = r_ovf_count;
    assign o_level_max = r_level_max;
`endif

endmodule
`default_nettype wire
